// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side handshake signals around the shared memory port.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              f_req_i;
  logic [ADDR_W-1:0] f_addr_i;
  logic              f_flush_i;
  logic              f_done_o;
  logic [DATA_W-1:0] f_rdata_o;
  logic              f_err_o;
  logic              f_wait_o;

  logic              m_req_i;
  logic              m_we_i;
  logic [ADDR_W-1:0] m_addr_i;
  logic [DATA_W-1:0] m_wdata_i;
  logic              m_done_o;
  logic [DATA_W-1:0] m_rdata_o;
  logic              m_err_o;
  logic              m_wait_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_err_i;

  modport slave (
    input  f_req_i, f_addr_i, f_flush_i,
    output f_done_o, f_rdata_o, f_err_o, f_wait_o,
    input  m_req_i, m_we_i, m_addr_i, m_wdata_i,
    output m_done_o, m_rdata_o, m_err_o, m_wait_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i, mem_err_i
  );

  modport master (
    output f_req_i, f_addr_i, f_flush_i,
    input  f_done_o, f_rdata_o, f_err_o, f_wait_o,
    output m_req_i, m_we_i, m_addr_i, m_wdata_i,
    input  m_done_o, m_rdata_o, m_err_o, m_wait_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (read-only) and data access (read/write).
// Data wins ties except when a fetch has been passed over MAX_STREAK times in a row.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
  localparam int unsigned TIMER_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, F_BUSY, M_BUSY} state_t;

  state_t              r_state, w_state_nxt;
  logic [STREAK_W-1:0] r_streak, w_streak_nxt;
  logic [TIMER_W-1:0]  r_timer, w_timer_nxt;
  logic                r_flush_pend, w_flush_pend_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic                r_f_done, w_f_done_nxt;
  logic                r_f_err, w_f_err_nxt;
  logic [DATA_W-1:0]   r_f_rdata, w_f_rdata_nxt;
  logic                r_m_done, w_m_done_nxt;
  logic                r_m_err, w_m_err_nxt;
  logic [DATA_W-1:0]   r_m_rdata, w_m_rdata_nxt;

  logic w_f_cand, w_m_cand, w_grant_m, w_grant_f;
  logic w_complete, w_timeout, w_streak_max;

  // A requester whose done pulse is showing is still holding its request; ignore it.
  assign w_f_cand     = bus.f_req_i & ~r_f_done;
  assign w_m_cand     = bus.m_req_i & ~r_m_done;
  assign w_streak_max = (r_streak == STREAK_W'(MAX_STREAK));

  always_comb begin
    w_state_nxt      = r_state;
    w_streak_nxt     = r_streak;
    w_timer_nxt      = r_timer;
    w_flush_pend_nxt = r_flush_pend;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_f_done_nxt     = 1'b0;
    w_f_err_nxt      = 1'b0;
    w_f_rdata_nxt    = '0;
    w_m_done_nxt     = 1'b0;
    w_m_err_nxt      = 1'b0;
    w_m_rdata_nxt    = '0;
    w_grant_m        = 1'b0;
    w_grant_f        = 1'b0;
    w_complete       = 1'b0;
    w_timeout        = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_grant_m = w_m_cand & ~(w_f_cand & w_streak_max);
        w_grant_f = w_f_cand & ~w_grant_m;
        if (w_grant_m) begin
          w_state_nxt     = M_BUSY;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = bus.m_we_i;
          w_mem_addr_nxt  = bus.m_addr_i;
          w_mem_wdata_nxt = bus.m_wdata_i;
          w_timer_nxt     = '0;
          if (!bus.f_req_i)       w_streak_nxt = '0;
          else if (!w_streak_max) w_streak_nxt = r_streak + STREAK_W'(1);
        end else if (w_grant_f) begin
          w_state_nxt      = F_BUSY;
          w_mem_req_nxt    = 1'b1;
          w_mem_we_nxt     = 1'b0;
          w_mem_addr_nxt   = bus.f_addr_i;
          w_mem_wdata_nxt  = '0;
          w_timer_nxt      = '0;
          w_streak_nxt     = '0;
          w_flush_pend_nxt = bus.f_flush_i;
        end
      end
      F_BUSY, M_BUSY: begin
        w_complete = bus.mem_ready_i;
        w_timeout  = ~bus.mem_ready_i & (r_timer == TIMER_W'(TIMEOUT - 1));
        if (r_state == F_BUSY && bus.f_flush_i) w_flush_pend_nxt = 1'b1;
        if (w_complete || w_timeout) begin
          w_state_nxt      = IDLE;
          w_mem_req_nxt    = 1'b0;
          w_timer_nxt      = '0;
          w_flush_pend_nxt = 1'b0;
          // A flushed fetch still finishes on the bus but reports nothing.
          if (r_state == F_BUSY) begin
            if (!(r_flush_pend || bus.f_flush_i)) begin
              w_f_done_nxt  = 1'b1;
              w_f_err_nxt   = w_complete ? bus.mem_err_i : 1'b1;
              w_f_rdata_nxt = w_complete ? bus.mem_rdata_i : '0;
            end
          end else begin
            w_m_done_nxt  = 1'b1;
            w_m_err_nxt   = w_complete ? bus.mem_err_i : 1'b1;
            w_m_rdata_nxt = (w_complete && !r_mem_we) ? bus.mem_rdata_i : '0;
          end
        end else begin
          w_timer_nxt = r_timer + TIMER_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_streak     <= '0;
      r_timer      <= '0;
      r_flush_pend <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_f_done     <= 1'b0;
      r_f_err      <= 1'b0;
      r_f_rdata    <= '0;
      r_m_done     <= 1'b0;
      r_m_err      <= 1'b0;
      r_m_rdata    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_streak     <= w_streak_nxt;
      r_timer      <= w_timer_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_f_done     <= w_f_done_nxt;
      r_f_err      <= w_f_err_nxt;
      r_f_rdata    <= w_f_rdata_nxt;
      r_m_done     <= w_m_done_nxt;
      r_m_err      <= w_m_err_nxt;
      r_m_rdata    <= w_m_rdata_nxt;
    end
  end

  assign bus.f_done_o    = r_f_done;
  assign bus.f_err_o     = r_f_err;
  assign bus.f_rdata_o   = r_f_rdata;
  assign bus.f_wait_o    = bus.f_req_i & ~r_f_done;
  assign bus.m_done_o    = r_m_done;
  assign bus.m_err_o     = r_m_err;
  assign bus.m_rdata_o   = r_m_rdata;
  assign bus.m_wait_o    = bus.m_req_i & ~r_m_done;
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand-written
// sequences for streak limit, timeout and reset abort.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned MAX_STREAK = 4;
  localparam int unsigned TIMEOUT    = 16;
  localparam int unsigned NVEC       = 22;

  localparam logic [63:0] A1  = 64'h100;
  localparam logic [63:0] A2  = 64'h200;
  localparam logic [63:0] RD1 = 64'h30F2_8000_0000_0001;
  localparam logic [63:0] RD2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] RX  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] RE  = 64'h5555;

  // in = {f_req, f_flush, m_req, m_we, mem_ready, mem_err}; w = {f_wait, m_wait} before the edge;
  // mem = {mem_req, mem_we}; f/m = {done, err}; all outputs observed after the edge
  typedef struct {
    logic [5:0]  in;
    logic [63:0] rd;
    logic [1:0]  w;
    logic [1:0]  mem;
    logic [63:0] maddr;
    logic [1:0]  f;
    logic [63:0] frd;
    logic [1:0]  m;
    logic [63:0] mrd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err = 0;
  vec_t tbl [NVEC];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  function automatic vec_t mk(input logic [5:0] in, input logic [63:0] rd, input logic [1:0] w,
                              input logic [1:0] mem, input logic [63:0] maddr,
                              input logic [1:0] f, input logic [63:0] frd,
                              input logic [1:0] m, input logic [63:0] mrd);
    vec_t v;
    v.in = in; v.rd = rd; v.w = w; v.mem = mem; v.maddr = maddr;
    v.f = f; v.frd = frd; v.m = m; v.mrd = mrd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] in, input logic [63:0] rd);
    {bus.f_req_i, bus.f_flush_i, bus.m_req_i, bus.m_we_i, bus.mem_ready_i, bus.mem_err_i} = in;
    bus.mem_rdata_i = rd;
  endtask

  task automatic step(input logic [5:0] in, input logic [63:0] rd);
    @(negedge clk);
    drive(in, rd);
    @(posedge clk);
    #1;
  endtask

  task automatic run_timeout(input logic late_ready, input logic [63:0] rd);
    logic bad;
    bad = 1'b0;
    step(6'b001000, '0);
    chk("timeout grant", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o}, {2'b10, A2});
    for (int k = 1; k < int'(TIMEOUT); k++) begin
      step(6'b001000, '0);
      if (!(bus.mem_req_o === 1'b1 && bus.m_done_o === 1'b0)) bad = 1'b1;
    end
    chk("timeout busy hold", bad, 1'b0);
    step({4'b0010, late_ready, 1'b0}, rd);
    chk(late_ready ? "ready at limit" : "timeout done",
        {bus.m_done_o, bus.m_err_o, bus.mem_req_o, bus.m_rdata_o},
        {1'b1, ~late_ready, 1'b0, (late_ready ? rd : 64'h0)});
    step(6'b001000, '0);
    chk("timeout after", {bus.mem_req_o, bus.m_done_o}, 2'b00);
    step(6'b000000, '0);
  endtask

  initial begin
    bus.f_addr_i  = A1;
    bus.m_addr_i  = A2;
    bus.m_wdata_i = 64'hAB;
    drive(6'b000000, '0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}, '0);
    chk("reset rsp", {bus.f_done_o, bus.f_err_o, bus.f_rdata_o,
                      bus.m_done_o, bus.m_err_o, bus.m_rdata_o}, '0);
    @(negedge clk);
    rst = 1'b0;

    // single fetch, ready on the first busy cycle
    tbl[0]  = mk(6'b100000, '0,  2'b10, 2'b10, A1, 2'b00, '0,  2'b00, '0);
    tbl[1]  = mk(6'b100010, RD1, 2'b10, 2'b00, A1, 2'b10, RD1, 2'b00, '0);
    tbl[2]  = mk(6'b100000, '0,  2'b00, 2'b00, A1, 2'b00, '0,  2'b00, '0);
    tbl[3]  = mk(6'b000000, '0,  2'b00, 2'b00, A1, 2'b00, '0,  2'b00, '0);
    // simultaneous: data write first, fetch in the data done cycle
    tbl[4]  = mk(6'b101100, '0,  2'b11, 2'b11, A2, 2'b00, '0,  2'b00, '0);
    tbl[5]  = mk(6'b101110, RX,  2'b11, 2'b01, A2, 2'b00, '0,  2'b10, '0);
    tbl[6]  = mk(6'b101100, '0,  2'b10, 2'b10, A1, 2'b00, '0,  2'b00, '0);
    tbl[7]  = mk(6'b100010, RD2, 2'b10, 2'b00, A1, 2'b10, RD2, 2'b00, '0);
    tbl[8]  = mk(6'b100000, '0,  2'b00, 2'b00, A1, 2'b00, '0,  2'b00, '0);
    // flushed fetch, then a fresh fetch
    tbl[9]  = mk(6'b100000, '0,  2'b10, 2'b10, A1, 2'b00, '0,  2'b00, '0);
    tbl[10] = mk(6'b110000, '0,  2'b10, 2'b10, A1, 2'b00, '0,  2'b00, '0);
    tbl[11] = mk(6'b100000, '0,  2'b10, 2'b10, A1, 2'b00, '0,  2'b00, '0);
    tbl[12] = mk(6'b100000, '0,  2'b10, 2'b10, A1, 2'b00, '0,  2'b00, '0);
    tbl[13] = mk(6'b100010, RD1, 2'b10, 2'b00, A1, 2'b00, '0,  2'b00, '0);
    tbl[14] = mk(6'b100000, '0,  2'b10, 2'b10, A1, 2'b00, '0,  2'b00, '0);
    tbl[15] = mk(6'b100010, RD2, 2'b10, 2'b00, A1, 2'b10, RD2, 2'b00, '0);
    tbl[16] = mk(6'b100000, '0,  2'b00, 2'b00, A1, 2'b00, '0,  2'b00, '0);
    tbl[17] = mk(6'b010000, '0,  2'b00, 2'b00, A1, 2'b00, '0,  2'b00, '0);
    // data read completing with an address error
    tbl[18] = mk(6'b001000, '0,  2'b01, 2'b10, A2, 2'b00, '0,  2'b00, '0);
    tbl[19] = mk(6'b001011, RE,  2'b01, 2'b00, A2, 2'b00, '0,  2'b11, RE);
    tbl[20] = mk(6'b001000, '0,  2'b00, 2'b00, A2, 2'b00, '0,  2'b00, '0);
    tbl[21] = mk(6'b000000, '0,  2'b00, 2'b00, A2, 2'b00, '0,  2'b00, '0);

    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      drive(tbl[i].in, tbl[i].rd);
      #1;
      chk($sformatf("v%0d wait", i), {bus.f_wait_o, bus.m_wait_o}, tbl[i].w);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d mem", i), {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o},
          {tbl[i].mem, tbl[i].maddr});
      chk($sformatf("v%0d fetch", i), {bus.f_done_o, bus.f_err_o, bus.f_rdata_o},
          {tbl[i].f, tbl[i].frd});
      chk($sformatf("v%0d data", i), {bus.m_done_o, bus.m_err_o, bus.m_rdata_o},
          {tbl[i].m, tbl[i].mrd});
    end

    // streak limit: fetch is dropped during each data done cycle so only data grants see it pending
    for (int i = 0; i < int'(MAX_STREAK); i++) begin
      step(6'b101100, '0);
      chk($sformatf("starve grant%0d", i), {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o},
          {2'b11, A2});
      step(6'b101110, RX);
      chk($sformatf("starve done%0d", i), {bus.m_done_o, bus.f_done_o}, 2'b10);
      step(6'b001100, '0);
      chk($sformatf("starve gap%0d", i), bus.mem_req_o, 1'b0);
    end
    step(6'b101100, '0);
    chk("forced fetch grant", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o}, {2'b10, A1});
    step(6'b101110, RD1);
    chk("forced fetch done", {bus.f_done_o, bus.m_done_o, bus.f_rdata_o}, {2'b10, RD1});
    step(6'b100000, '0);
    chk("forced fetch gap", bus.mem_req_o, 1'b0);
    step(6'b101100, '0);
    chk("streak cleared", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o}, {2'b11, A2});
    step(6'b101110, RX);
    chk("streak cleared done", {bus.m_done_o, bus.m_rdata_o}, {1'b1, 64'h0});
    step(6'b000000, '0);

    run_timeout(1'b0, RX);
    run_timeout(1'b1, RD2);

    // reset while the data transaction is outstanding
    step(6'b001100, '0);
    chk("abort grant", bus.mem_req_o, 1'b1);
    step(6'b001100, '0);
    chk("abort busy", bus.mem_req_o, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive(6'b001110, RX);
    @(posedge clk);
    #1;
    chk("abort mem", {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}, '0);
    chk("abort rsp", {bus.m_done_o, bus.m_err_o, bus.m_rdata_o, bus.f_done_o}, '0);
    @(negedge clk);
    rst = 1'b0;
    drive(6'b000000, '0);
    @(posedge clk);
    #1;
    chk("abort no done", {bus.m_done_o, bus.mem_req_o}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single shared memory port between the fetch stage (read-only) and the memory-access stage (read/write) of the Y86-64 pipeline. It latches one request at a time, drives the memory handshake, and returns data or an error with a one-cycle done pulse. Per-requester wait flags feed the pipeline controller's stall logic. Data requests have priority, backed by an anti-starvation streak limit and a response timeout.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
MAX_STREAK, 4, consecutive data grants allowed while fetch is pending before fetch is forced
TIMEOUT, 16, cycles in a busy state without mem_ready_i before the transaction is aborted with error

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous, active-high reset
f_req_i  in  1  fetch read request, held until f_done_o
f_addr_i  in  ADDR_W  fetch address
f_flush_i  in  1  mispredict flush; discards an in-flight fetch result
f_done_o  out  1  one-cycle fetch completion pulse
f_rdata_o  out  DATA_W  fetch read data, valid with f_done_o
f_err_o  out  1  fetch error (mem_err_i or timeout), valid with f_done_o
f_wait_o  out  1  f_req_i high and f_done_o low (combinational)
m_req_i  in  1  data request, held until m_done_o
m_we_i  in  1  1 = write, 0 = read
m_addr_i  in  ADDR_W  data address
m_wdata_i  in  DATA_W  write data
m_done_o  out  1  one-cycle data completion pulse
m_rdata_o  out  DATA_W  read data, valid with m_done_o (0 on writes)
m_err_o  out  1  data error, valid with m_done_o
m_wait_o  out  1  m_req_i high and m_done_o low (combinational)
mem_req_o  out  1  memory request, high throughout a busy state
mem_we_o  out  1  latched write enable
mem_addr_o  out  ADDR_W  latched address
mem_wdata_o  out  DATA_W  latched write data
mem_ready_i  in  1  memory completes the transaction this cycle
mem_rdata_i  in  DATA_W  read data, valid with mem_ready_i
mem_err_i  in  1  address error, valid with mem_ready_i

Behaviour:
- Reset: state IDLE, streak=0, timer=0, flush_pend=0. All outputs 0, including the latched mem_* fields and the rdata registers.
- States: IDLE, F_BUSY, M_BUSY.
- IDLE grant rules. A requester whose done pulse is high this cycle is ignored. Within the remaining requests:
  - m_req only: grant data.
  - f_req only: grant fetch.
  - both: grant data unless streak==MAX_STREAK, in which case grant fetch.
- On a grant, latch addr, we and wdata (we=0 for fetch) and move to the matching BUSY state. mem_req_o is 1 from the next cycle.
- Streak counter:
  - A data grant with f_req_i high increments streak (saturating).
  - A data grant with f_req_i low clears streak.
  - A fetch grant clears streak.
- BUSY states: mem_req_o and the mem_* fields stay stable. The timer counts up each cycle.
- mem_ready_i sampled high: on the next cycle, the owner's done=1, rdata=mem_rdata_i (m_rdata_o=0 for writes), err=mem_err_i. State returns to IDLE and the timer clears.
- Timeout: when the timer reaches TIMEOUT-1 with no mem_ready_i, the next cycle drops mem_req_o, pulses done with err=1 and rdata=0, and returns to IDLE. A mem_ready_i in that same cycle wins over the timeout.
- Latency: request sampled at cycle 0 gives mem_req_o at cycle 1. mem_ready_i at cycle k gives done at k+1. Minimum request-to-done is 2 cycles. Back-to-back grants are spaced 3 cycles (grant, busy, done/IDLE).
- Flush:
  - f_flush_i in F_BUSY (or in the grant cycle for fetch) sets flush_pend. The memory transaction still runs to completion, but f_done_o, f_rdata_o and f_err_o are suppressed. flush_pend clears on return to IDLE.
  - f_flush_i in IDLE or M_BUSY has no effect.
- Done pulses last exactly one cycle. Done, rdata and err return to 0 on the following cycle.
- rst_i mid-transaction aborts immediately: state IDLE, mem_req_o=0 next cycle, no done pulse.

Test Plan:
- Single fetch: f_addr=0x100, mem_ready at the first busy cycle with rdata=0x30F2... → mem_req_o high 1 cycle, f_done_o at cycle 2 with f_rdata_o=0x30F2..., f_err_o=0.
- Simultaneous requests: f_req and m_req (write, addr 0x200, wdata 0xAB) both at cycle 0 → data granted first (mem_we_o=1, addr 0x200), m_done_o pulses, then fetch granted; m_rdata_o=0.
- Starvation: f_req held while m_req is re-asserted continuously → exactly 4 data grants, then the fetch grant, then streak=0.
- Timeout: m_req read with mem_ready never asserted → m_done_o=1 and m_err_o=1 at cycle 1+TIMEOUT, mem_req_o drops, state IDLE.
- Flush: fetch granted, f_flush_i pulsed in the busy cycle, mem_ready 3 cycles later → no f_done_o; a new fetch granted normally afterwards.
- Reset mid-M_BUSY plus mem_err: rst_i during busy → all outputs 0 next cycle, no done. Separately, mem_ready with mem_err_i=1 → m_err_o=1 alongside m_done_o.
